// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//
// Pointer and flag controller for the fifo_mem storage array used by the UART
// TX and RX buffers. It turns push/pop requests from the UART datapath into
// memory write strobes and addresses. It also keeps the occupancy count,
// full/empty/threshold flags and sticky overflow/underflow error flags.
//
// Read data is first-word-fall-through: the memory reads combinationally at
// rd_addr, so the head entry is on the memory's data_out whenever empty = 0.
//
// Parameters
//   FIFO_DEPTH    number of entries, 2 .. 2**FIFO_C_WIDTH
//   FIFO_C_WIDTH  memory address width
//   AF_LEVEL      almost_full  when count >= AF_LEVEL
//   AE_LEVEL      almost_empty when count <= AE_LEVEL
//
// Ports
//   clk           system clock, all state updates on the rising edge
//   rst_n         synchronous active-low reset
//   push          write request (data presented to memory in the same cycle)
//   pop           read request, consumes the head entry
//   flush         empties the FIFO, error flags kept
//   clr_err       clears overflow / underflow
//   wr_en         memory write strobe (the only combinational output)
//   wr_addr       memory write address (tail pointer)
//   rd_addr       memory read address (head pointer)
//   count         occupancy, 0 .. FIFO_DEPTH
//   full, empty, almost_full, almost_empty   status flags
//   overflow, underflow                      sticky error flags
// -----------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_C_WIDTH = 4,
  parameter int AF_LEVEL     = 12,
  parameter int AE_LEVEL     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic                    clr_err,
  output logic                    wr_en,
  output logic [FIFO_C_WIDTH-1:0] wr_addr,
  output logic [FIFO_C_WIDTH-1:0] rd_addr,
  output logic [FIFO_C_WIDTH:0]   count,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam logic [FIFO_C_WIDTH-1:0] LAST_ADDR = FIFO_C_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [FIFO_C_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [FIFO_C_WIDTH-1:0] ADDR_ONE  = FIFO_C_WIDTH'(1);
  localparam logic [FIFO_C_WIDTH:0]   CNT_ZERO  = '0;
  localparam logic [FIFO_C_WIDTH:0]   CNT_ONE   = (FIFO_C_WIDTH + 1)'(1);
  localparam logic [FIFO_C_WIDTH:0]   CNT_FULL  = (FIFO_C_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_C_WIDTH:0]   CNT_AF    = (FIFO_C_WIDTH + 1)'(AF_LEVEL);
  localparam logic [FIFO_C_WIDTH:0]   CNT_AE    = (FIFO_C_WIDTH + 1)'(AE_LEVEL);

  logic [FIFO_C_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [FIFO_C_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [FIFO_C_WIDTH:0]   count_reg, count_next;
  logic                    overflow_reg, overflow_next;
  logic                    underflow_reg, underflow_next;

  logic full_flag;
  logic empty_flag;
  logic push_ok;
  logic pop_ok;

  // Wrap explicitly at the last entry so non-power-of-2 depths work.
  function automatic logic [FIFO_C_WIDTH-1:0] ptr_inc(input logic [FIFO_C_WIDTH-1:0] ptr);
    if (ptr == LAST_ADDR) begin
      return ADDR_ZERO;
    end
    return ptr + ADDR_ONE;
  endfunction

  // Flags come only from the registered count, so push/pop have no
  // combinational path to them.
  assign full_flag  = (count_reg == CNT_FULL);
  assign empty_flag = (count_reg == CNT_ZERO);

  // Gate on registered full only. This keeps the write strobe free of any
  // path from pop. rst_n is included so the memory is never written while
  // reset is held.
  assign push_ok = push & ~full_flag & ~flush & rst_n;
  assign pop_ok  = pop & ~empty_flag & ~flush;

  // Next-state logic
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;

    if (flush) begin
      wr_ptr_next = ADDR_ZERO;
      rd_ptr_next = ADDR_ZERO;
      count_next  = CNT_ZERO;
    end else begin
      if (push_ok) begin
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop_ok) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end

    // A new error in the same cycle as clr_err wins, so it is never lost.
    overflow_next  = (overflow_reg  & ~clr_err) | (push & full_flag  & ~flush);
    underflow_next = (underflow_reg & ~clr_err) | (pop  & empty_flag & ~flush);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= ADDR_ZERO;
      rd_ptr_reg    <= ADDR_ZERO;
      count_reg     <= CNT_ZERO;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Outputs
  assign wr_en        = push_ok;
  assign wr_addr      = wr_ptr_reg;
  assign rd_addr      = rd_ptr_reg;
  assign count        = count_reg;
  assign full         = full_flag;
  assign empty        = empty_flag;
  assign almost_full  = (count_reg >= CNT_AF);
  assign almost_empty = (count_reg <= CNT_AE);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

  logic clk;
  logic rst_n;

  // DEPTH = 16 instance
  logic       push16, pop16, flush16, clr16;
  logic       wr_en16, full16, empty16, af16, ae16, ovf16, unf16;
  logic [3:0] wr_addr16, rd_addr16;
  logic [4:0] count16;
  logic [7:0] din16;
  logic [7:0] mem16 [16];
  logic [7:0] data_out16;

  // DEPTH = 12 instance
  logic       push12, pop12, flush12, clr12;
  logic       wr_en12, full12, empty12, af12, ae12, ovf12, unf12;
  logic [3:0] wr_addr12, rd_addr12;
  logic [4:0] count12;
  logic [7:0] din12;
  logic [7:0] mem12 [12];
  logic [7:0] data_out12;

  int checks = 0;
  int errors = 0;

  // {wr_addr, rd_addr, count, full, empty, af, ae, ovf, unf, wr_en}
  logic [19:0] st16, st12;
  localparam logic [19:0] RST_STATE = {4'd0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  assign st16 = {wr_addr16, rd_addr16, count16, full16, empty16, af16, ae16, ovf16, unf16, wr_en16};
  assign st12 = {wr_addr12, rd_addr12, count12, full12, empty12, af12, ae12, ovf12, unf12, wr_en12};

  fifo_ctrl #(.FIFO_DEPTH(16), .FIFO_C_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .push(push16), .pop(pop16), .flush(flush16), .clr_err(clr16),
    .wr_en(wr_en16), .wr_addr(wr_addr16), .rd_addr(rd_addr16), .count(count16),
    .full(full16), .empty(empty16), .almost_full(af16), .almost_empty(ae16),
    .overflow(ovf16), .underflow(unf16)
  );

  fifo_ctrl #(.FIFO_DEPTH(12), .FIFO_C_WIDTH(4), .AF_LEVEL(9), .AE_LEVEL(3)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .push(push12), .pop(pop12), .flush(flush12), .clr_err(clr12),
    .wr_en(wr_en12), .wr_addr(wr_addr12), .rd_addr(rd_addr12), .count(count12),
    .full(full12), .empty(empty12), .almost_full(af12), .almost_empty(ae12),
    .overflow(ovf12), .underflow(unf12)
  );

  // Storage arrays standing in for fifo_mem: synchronous write, async read.
  always @(posedge clk) begin
    if (wr_en16) mem16[wr_addr16] <= din16;
    if (wr_en12) mem12[wr_addr12] <= din12;
  end
  assign data_out16 = mem16[rd_addr16];
  assign data_out12 = mem12[rd_addr12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (st16 !== RST_STATE) begin
      errors++;
      $display("FAIL reset16: got %h expected %h", st16, RST_STATE);
    end
    checks++;
    if (st12 !== RST_STATE) begin
      errors++;
      $display("FAIL reset12: got %h expected %h", st12, RST_STATE);
    end
    rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (st16 !== RST_STATE) begin
      errors++;
      $display("FAIL idle16: got %h expected %h", st16, RST_STATE);
    end
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    push16 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din16 = 8'(i);
      #1;
      checks++;
      if (wr_en16 !== 1'b1 || wr_addr16 !== 4'(i)) begin
        errors++;
        $display("FAIL fill_wr[%0d]: wr_en=%b wr_addr=%0d expected 1/%0d", i, wr_en16, wr_addr16, i);
      end
      tick();
      checks++;
      if (count16 !== 5'(i + 1) || af16 !== (i + 1 >= 12) || ae16 !== (i + 1 <= 4)) begin
        errors++;
        $display("FAIL fill_cnt[%0d]: count=%0d af=%b ae=%b expected %0d/%b/%b",
                 i, count16, af16, ae16, i + 1, (i + 1 >= 12), (i + 1 <= 4));
      end
    end
    checks++;
    if (full16 !== 1'b1 || ovf16 !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: full=%b ovf=%b expected 1/0", full16, ovf16);
    end
    din16 = 8'hAA;
    #1;
    checks++;
    if (wr_en16 !== 1'b0) begin
      errors++;
      $display("FAIL push17_wr_en: got %b expected 0", wr_en16);
    end
    tick();
    checks++;
    if (ovf16 !== 1'b1 || wr_addr16 !== 4'd0 || count16 !== 5'd16) begin
      errors++;
      $display("FAIL push17: ovf=%b wr_addr=%0d count=%0d expected 1/0/16", ovf16, wr_addr16, count16);
    end
    push16 = 1'b0;
    pop16  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (data_out16 !== 8'(i) || rd_addr16 !== 4'(i)) begin
        errors++;
        $display("FAIL drain[%0d]: data=%h rd_addr=%0d expected %h/%0d", i, data_out16, rd_addr16, 8'(i), i);
      end
      tick();
    end
    checks++;
    if (empty16 !== 1'b1 || count16 !== 5'd0 || unf16 !== 1'b0) begin
      errors++;
      $display("FAIL drained: empty=%b count=%0d unf=%b expected 1/0/0", empty16, count16, unf16);
    end
    tick();
    checks++;
    if (unf16 !== 1'b1 || rd_addr16 !== 4'd0) begin
      errors++;
      $display("FAIL extra_pop: unf=%b rd_addr=%0d expected 1/0", unf16, rd_addr16);
    end
    pop16 = 1'b0;
    clr16 = 1'b1;
    tick();
    clr16 = 1'b0;
    checks++;
    if (ovf16 !== 1'b0 || unf16 !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: ovf=%b unf=%b expected 0/0", ovf16, unf16);
    end
    $display("test_fill_drain done");
  endtask

  task automatic test_wrap();
    push12 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din12 = 8'(8'h20 + i);
      tick();
    end
    push12 = 1'b0;
    pop12  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (data_out12 !== 8'(8'h20 + i)) begin
        errors++;
        $display("FAIL wrap_pop1[%0d]: data=%h expected %h", i, data_out12, 8'(8'h20 + i));
      end
      tick();
    end
    pop12  = 1'b0;
    push12 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din12 = 8'(8'h30 + i);
      #1;
      checks++;
      if (wr_addr12 !== 4'((8 + i) % 12) || wr_en12 !== 1'b1) begin
        errors++;
        $display("FAIL wrap_wr[%0d]: wr_addr=%0d wr_en=%b expected %0d/1", i, wr_addr12, wr_en12, (8 + i) % 12);
      end
      tick();
    end
    push12 = 1'b0;
    checks++;
    if (count12 !== 5'd8 || wr_addr12 !== 4'd4) begin
      errors++;
      $display("FAIL wrap_count: count=%0d wr_addr=%0d expected 8/4", count12, wr_addr12);
    end
    pop12 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (data_out12 !== 8'(8'h30 + i) || rd_addr12 !== 4'((8 + i) % 12)) begin
        errors++;
        $display("FAIL wrap_rd[%0d]: data=%h rd_addr=%0d expected %h/%0d",
                 i, data_out12, rd_addr12, 8'(8'h30 + i), (8 + i) % 12);
      end
      tick();
    end
    pop12 = 1'b0;
    checks++;
    if (empty12 !== 1'b1 || unf12 !== 1'b0 || ovf12 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: empty=%b unf=%b ovf=%b expected 1/0/0", empty12, unf12, ovf12);
    end
    $display("test_wrap done");
  endtask

  task automatic test_simultaneous();
    push16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din16 = 8'(8'h40 + i);
      tick();
    end
    pop16 = 1'b1;
    din16 = 8'h45;
    #1;
    checks++;
    if (wr_en16 !== 1'b1) begin
      errors++;
      $display("FAIL both5_wr_en: got %b expected 1", wr_en16);
    end
    tick();
    checks++;
    if (count16 !== 5'd5 || wr_addr16 !== 4'd6 || rd_addr16 !== 4'd1 || data_out16 !== 8'h41) begin
      errors++;
      $display("FAIL both5: count=%0d wr=%0d rd=%0d data=%h expected 5/6/1/41",
               count16, wr_addr16, rd_addr16, data_out16);
    end
    pop16 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      din16 = 8'(8'h46 + i);
      tick();
    end
    checks++;
    if (full16 !== 1'b1 || wr_addr16 !== 4'd1) begin
      errors++;
      $display("FAIL refill: full=%b wr=%0d expected 1/1", full16, wr_addr16);
    end
    pop16 = 1'b1;
    din16 = 8'hEE;
    #1;
    checks++;
    if (wr_en16 !== 1'b0) begin
      errors++;
      $display("FAIL both_full_wr_en: got %b expected 0", wr_en16);
    end
    tick();
    checks++;
    if (count16 !== 5'd15 || ovf16 !== 1'b1 || rd_addr16 !== 4'd2 || wr_addr16 !== 4'd1) begin
      errors++;
      $display("FAIL both_full: count=%0d ovf=%b rd=%0d wr=%0d expected 15/1/2/1",
               count16, ovf16, rd_addr16, wr_addr16);
    end
    push16 = 1'b0;
    repeat (15) tick();
    checks++;
    if (empty16 !== 1'b1 || rd_addr16 !== 4'd1) begin
      errors++;
      $display("FAIL drain15: empty=%b rd=%0d expected 1/1", empty16, rd_addr16);
    end
    push16 = 1'b1;
    din16  = 8'h77;
    #1;
    checks++;
    if (wr_en16 !== 1'b1) begin
      errors++;
      $display("FAIL both_empty_wr_en: got %b expected 1", wr_en16);
    end
    tick();
    push16 = 1'b0;
    pop16  = 1'b0;
    checks++;
    if (count16 !== 5'd1 || unf16 !== 1'b1 || wr_addr16 !== 4'd2 || rd_addr16 !== 4'd1 || data_out16 !== 8'h77) begin
      errors++;
      $display("FAIL both_empty: count=%0d unf=%b wr=%0d rd=%0d data=%h expected 1/1/2/1/77",
               count16, unf16, wr_addr16, rd_addr16, data_out16);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_flush();
    push16 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din16 = 8'(8'h60 + i);
      tick();
    end
    checks++;
    if (count16 !== 5'd7) begin
      errors++;
      $display("FAIL pre_flush: count=%0d expected 7", count16);
    end
    pop16   = 1'b1;
    flush16 = 1'b1;
    #1;
    checks++;
    if (wr_en16 !== 1'b0) begin
      errors++;
      $display("FAIL flush_wr_en: got %b expected 0", wr_en16);
    end
    tick();
    push16  = 1'b0;
    pop16   = 1'b0;
    flush16 = 1'b0;
    checks++;
    if (count16 !== 5'd0 || empty16 !== 1'b1 || wr_addr16 !== 4'd0 || rd_addr16 !== 4'd0 ||
        ovf16 !== 1'b1 || unf16 !== 1'b1) begin
      errors++;
      $display("FAIL flush: count=%0d empty=%b wr=%0d rd=%0d ovf=%b unf=%b expected 0/1/0/0/1/1",
               count16, empty16, wr_addr16, rd_addr16, ovf16, unf16);
    end
    $display("test_flush done");
  endtask

  task automatic test_clr_coincident();
    push16 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din16 = 8'(i);
      tick();
    end
    clr16 = 1'b1;
    tick();
    push16 = 1'b0;
    checks++;
    if (ovf16 !== 1'b1 || unf16 !== 1'b0) begin
      errors++;
      $display("FAIL clr_with_ovf: ovf=%b unf=%b expected 1/0", ovf16, unf16);
    end
    tick();
    clr16 = 1'b0;
    checks++;
    if (ovf16 !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone: ovf=%b expected 0", ovf16);
    end
    $display("test_clr_coincident done");
  endtask

  task automatic test_reset_mid();
    flush16 = 1'b1;
    tick();
    flush16 = 1'b0;
    push16  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      din16 = 8'(8'h80 + i);
      tick();
    end
    checks++;
    if (count16 !== 5'd9) begin
      errors++;
      $display("FAIL pre_reset: count=%0d expected 9", count16);
    end
    pop16 = 1'b1;
    rst_n = 1'b0;
    tick();
    checks++;
    if (st16 !== RST_STATE) begin
      errors++;
      $display("FAIL reset_mid: got %h expected %h", st16, RST_STATE);
    end
    push16 = 1'b0;
    pop16  = 1'b0;
    rst_n  = 1'b1;
    tick();
    checks++;
    if (st16 !== RST_STATE) begin
      errors++;
      $display("FAIL reset_mid_release: got %h expected %h", st16, RST_STATE);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst_n   = 1'b0;
    push16  = 1'b0; pop16 = 1'b0; flush16 = 1'b0; clr16 = 1'b0; din16 = 8'h00;
    push12  = 1'b0; pop12 = 1'b0; flush12 = 1'b0; clr12 = 1'b0; din12 = 8'h00;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_clr_coincident();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
